// File: rtl/nonce_pkg.sv
// nonce_pkg: shared widths, FSM state type and lowest-set-bit helper for nonce_collector.
`default_nettype none

package nonce_pkg;

  localparam int DEF_NUM_CORES  = 10;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int IDX_W          = $clog2(DEF_NUM_CORES);
  localparam int PTR_W          = $clog2(DEF_FIFO_DEPTH);

  // Priority search runs over a fixed-width vector; callers zero-extend.
  localparam int LSB_W     = 64;
  localparam int LSB_IDX_W = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

  typedef struct packed {
    logic                 valid;
    logic [LSB_IDX_W-1:0] idx;
  } lsb_t;

  function automatic lsb_t lowest_set(input logic [LSB_W-1:0] vec);
    lsb_t r;
    r = '0;
    for (int i = LSB_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        r.valid = 1'b1;
        r.idx   = i[LSB_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nonce_fifo.sv
// nonce_fifo: first-word-fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
`default_nettype none

module nonce_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic             empty_o,
  output logic [WIDTH-1:0] data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign data_o  = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wr_q] = data_i;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/nonce_collector.sv
// nonce_collector: rebuilds absolute winning nonces from per-beat core results, queues them, reports per-block summary.
// Optional feature: NONCE_EARLY_EXIT_EN ends a block at its first pushed nonce.
`default_nettype none

module nonce_collector
  import nonce_pkg::*;
#(
  parameter int NUM_CORES   = DEF_NUM_CORES,
  parameter int NONCE_RANGE = 100,
  parameter int NONCE_W     = 32,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 newblock_i,
  input  logic [NUM_CORES-1:0] success_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [NONCE_W-1:0]   res_nonce_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_W-1:0]     hit_cnt_o,
  output logic                 drop_o
);

  localparam int PC_W  = $clog2(NUM_CORES + 1);
  localparam int SUM_W = CNT_W + PC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  logic [NONCE_W-1:0]   base_q, base_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, hit_cnt_q, hit_cnt_d;
  logic                 drop_q, drop_d, drop_out_q, drop_out_d, done_q, done_d;

  logic                 proc, push, pop, last, fifo_full, fifo_empty;
  logic [NONCE_W-1:0]   cur_base, push_nonce;
  logic [NUM_CORES-1:0] masked;
  logic [PC_W-1:0]      hits;
  lsb_t                 win;
  logic [CNT_W-1:0]     start_cnt;
  logic                 start_drop;
  logic [SUM_W-1:0]     sum;

  always_comb begin
    cur_base = newblock_i ? '0 : base_q;
    masked   = '0;
    hits     = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      masked[k] = success_i[k] && ((cur_base + NONCE_W'(k)) < NONCE_W'(NONCE_RANGE));
      hits      = hits + PC_W'(masked[k]);
    end
    win        = lowest_set(LSB_W'(masked));
    proc       = valid_i && (newblock_i || (state_q == SCAN));
    push       = proc && win.valid;
    push_nonce = cur_base + NONCE_W'(win.idx);
    pop        = !fifo_empty && res_ready_i;
    last       = (cur_base + NONCE_W'(NUM_CORES)) >= NONCE_W'(NONCE_RANGE);
`ifdef NONCE_EARLY_EXIT_EN
    last       = last || win.valid;
`endif
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    hit_cnt_d  = hit_cnt_q;
    drop_out_d = drop_out_q;
    done_d     = 1'b0;
    start_cnt  = newblock_i ? '0 : cnt_q;
    start_drop = newblock_i ? 1'b0 : drop_q;
    sum        = SUM_W'(start_cnt) + SUM_W'(hits);
    if (proc) begin
      cnt_d  = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
      // Extra same-beat winners and pushes refused by a full FIFO are lost.
      drop_d = start_drop || (hits > PC_W'(1)) || (push && fifo_full && !pop);
      if (newblock_i) begin
        hit_cnt_d  = '0;
        drop_out_d = 1'b0;
      end
      if (last) begin
        state_d    = IDLE;
        base_d     = '0;
        done_d     = 1'b1;
        hit_cnt_d  = cnt_d;
        drop_out_d = drop_d;
      end else begin
        state_d = SCAN;
        base_d  = cur_base + NONCE_W'(NUM_CORES);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      drop_q     <= 1'b0;
      hit_cnt_q  <= '0;
      drop_out_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      hit_cnt_q  <= hit_cnt_d;
      drop_out_q <= drop_out_d;
      done_q     <= done_d;
    end
  end

  nonce_fifo #(
    .WIDTH (NONCE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_nonce),
    .full_o  (fifo_full),
    .pop_i   (res_ready_i),
    .empty_o (fifo_empty),
    .data_o  (res_nonce_o)
  );

  assign res_valid_o = !fifo_empty;
  assign busy_o      = (state_q == SCAN);
  assign done_o      = done_q;
  assign hit_cnt_o   = hit_cnt_q;
  assign drop_o      = drop_out_q;

endmodule

`default_nettype wire

// File: tb/tb_nonce_collector.sv
// tb_nonce_collector: directed checks of nonce_collector (default range and a NONCE_RANGE=95 instance).
`default_nettype none

module tb_nonce_collector;

`ifdef NONCE_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, newblock_i, res_ready_i;
  logic [9:0]  success_i;

  logic        res_valid_o, busy_o, done_o, drop_o;
  logic [31:0] res_nonce_o;
  logic [7:0]  hit_cnt_o;

  logic        r95_valid, r95_busy, r95_done, r95_drop;
  logic [31:0] r95_nonce;
  logic [7:0]  r95_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nonce_collector dut (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .newblock_i  (newblock_i),
    .success_i   (success_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_nonce_o (res_nonce_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .hit_cnt_o   (hit_cnt_o),
    .drop_o      (drop_o)
  );

  nonce_collector #(.NONCE_RANGE(95)) dut95 (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (valid_i),
    .newblock_i  (newblock_i),
    .success_i   (success_i),
    .res_valid_o (r95_valid),
    .res_ready_i (res_ready_i),
    .res_nonce_o (r95_nonce),
    .busy_o      (r95_busy),
    .done_o      (r95_done),
    .hit_cnt_o   (r95_cnt),
    .drop_o      (r95_drop)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the capturing posedge.
  task automatic beat(input logic nb, input logic [9:0] s);
    valid_i    = 1'b1;
    newblock_i = nb;
    success_i  = s;
    @(negedge clk);
    valid_i    = 1'b0;
    newblock_i = 1'b0;
    success_i  = '0;
  endtask

  task automatic run_block(input logic [9:0] s [10], input int done_at, input int ready_at);
    for (int k = 0; k < 10; k++) begin
      res_ready_i = (k == ready_at);
      beat(k == 0, s[k]);
      res_ready_i = 1'b0;
      chk($sformatf("done_b%0d", k), 32'(done_o), 32'(k == done_at));
      chk($sformatf("busy_b%0d", k), 32'(busy_o), 32'(k < done_at));
    end
  endtask

  task automatic pop_chk(input logic [31:0] exp);
    chk("head_valid", 32'(res_valid_o), 32'd1);
    chk("head_nonce", res_nonce_o, exp);
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
  endtask

  logic [9:0] v [10];

  initial begin
    rst = 1'b0; valid_i = 1'b0; newblock_i = 1'b0; res_ready_i = 1'b0; success_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(res_valid_o), 32'd0);
    chk("rst_nonce", res_nonce_o, 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_cnt", 32'(hit_cnt_o), 32'd0);
    chk("rst_drop", 32'(drop_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Beat without newblock while idle is ignored.
    beat(1'b0, 10'h3FF);
    chk("idle_ign_valid", 32'(res_valid_o), 32'd0);
    chk("idle_ign_busy", 32'(busy_o), 32'd0);

    // Single hit: beat 3 bit 7 -> nonce 37.
    v = '{10'd0, 10'd0, 10'd0, 10'b0010000000, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
    run_block(v, EARLY ? 3 : 9, -1);
    chk("single_cnt", 32'(hit_cnt_o), 32'd1);
    chk("single_drop", 32'(drop_o), 32'd0);
    @(negedge clk);
    chk("done_pulse", 32'(done_o), 32'd0);
    pop_chk(32'd37);
    chk("single_empty", 32'(res_valid_o), 32'd0);

    // Same-beat multi-hit: bits 1,2,5 -> nonce 1 only.
    v = '{10'b0000100110, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
    run_block(v, EARLY ? 0 : 9, -1);
    chk("multi_cnt", 32'(hit_cnt_o), 32'd3);
    chk("multi_drop", 32'(drop_o), 32'd1);
    pop_chk(32'd1);
    chk("multi_empty", 32'(res_valid_o), 32'd0);

`ifndef NONCE_EARLY_EXIT_EN
    // FIFO overflow: nonces 2,15,28,41,54 with no consumer.
    v = '{10'b0000000100, 10'b0000100000, 10'b0100000000, 10'd0, 10'b0000000010,
          10'b0000010000, 10'd0, 10'd0, 10'd0, 10'd0};
    run_block(v, 9, -1);
    chk("full_cnt", 32'(hit_cnt_o), 32'd5);
    chk("full_drop", 32'(drop_o), 32'd1);
    pop_chk(32'd2); pop_chk(32'd15); pop_chk(32'd28); pop_chk(32'd41);
    chk("full_empty", 32'(res_valid_o), 32'd0);

    // Same pattern, pop coincides with the push of 54.
    run_block(v, 9, 5);
    chk("fullpop_cnt", 32'(hit_cnt_o), 32'd5);
    chk("fullpop_drop", 32'(drop_o), 32'd0);
    pop_chk(32'd15); pop_chk(32'd28); pop_chk(32'd41); pop_chk(32'd54);
    chk("fullpop_empty", 32'(res_valid_o), 32'd0);
`endif

    // Early-exit pattern: beat 2 bit 4 (24), later beat 5 bit 1 (51).
    v = '{10'd0, 10'd0, 10'b0000010000, 10'd0, 10'd0, 10'b0000000010, 10'd0, 10'd0, 10'd0, 10'd0};
    run_block(v, EARLY ? 2 : 9, -1);
    chk("early_cnt", 32'(hit_cnt_o), EARLY ? 32'd1 : 32'd2);
    chk("early_drop", 32'(drop_o), 32'd0);
    pop_chk(32'd24);
    if (!EARLY) pop_chk(32'd51);
    chk("early_empty", 32'(res_valid_o), 32'd0);

    res_ready_i = 1'b1;
    repeat (6) @(negedge clk);
    res_ready_i = 1'b0;

    // Range mask: last beat base 90, all cores hit.
    v = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'h3FF};
    run_block(v, 9, -1);
    chk("r95_done", 32'(r95_done), 32'd1);
    chk("r95_cnt", 32'(r95_cnt), 32'd5);
    chk("r95_drop", 32'(r95_drop), 32'd1);
    chk("r95_head", r95_nonce, 32'd90);
    chk("r100_cnt", 32'(hit_cnt_o), 32'd10);
    chk("r100_head", res_nonce_o, 32'd90);

    // Asynchronous reset while idle with summary and FIFO populated.
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(res_valid_o), 32'd0);
    chk("arst_nonce", res_nonce_o, 32'd0);
    chk("arst_cnt", 32'(hit_cnt_o), 32'd0);
    chk("arst_drop", 32'(drop_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Abort at base 40, restart; next beat uses base 10.
    beat(1'b1, 10'd0);
    repeat (3) beat(1'b0, 10'd0);
    beat(1'b1, 10'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd1);
    beat(1'b0, 10'b0000001000);
    chk("restart_nonce", res_nonce_o, 32'd13);
    chk("restart_done", 32'(done_o), 32'(EARLY));
    chk("restart_busy", 32'(busy_o), 32'(!EARLY));

    // Mid-scan asynchronous reset.
    #2 rst = 1'b0;
    #1;
    chk("mrst_valid", 32'(res_valid_o), 32'd0);
    chk("mrst_nonce", res_nonce_o, 32'd0);
    chk("mrst_busy", 32'(busy_o), 32'd0);
    chk("mrst_done", 32'(done_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
